// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the demux lane collector.
//   LANES          : number of demux lanes (fixed at 4, one per demux output)
//   SEL_W          : width of the lane select
//   DATA_W_DEFAULT : default number of bits per assembled lane word
//   lane_lo()      : low bit index of a lane's word inside a packed bus
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam int LANES          = 4;
    localparam int SEL_W          = 2;
    localparam int DATA_W_DEFAULT = 8;

    // Lane k occupies [k*width +: width] of any packed per-lane word bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/demux_lane_collector_lane_packer.sv
// ----------------------------------------------------------------------------
// lane_packer
// Serial-to-parallel packer for one demux lane. Bits arrive LSB first. A
// finished word moves into a one-deep holding register that is presented on
// a valid/ready output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   take       : a bit for this lane is accepted this cycle
//   bit_in     : the accepted bit
//   out_ready  : consumer accepts the held word
//   can_take   : low only when the next bit would finish a word while the
//                held word is still waiting and is not leaving this cycle
//   data       : held word
//   valid      : held word is available
// ----------------------------------------------------------------------------
module lane_packer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              take,
    input  logic              bit_in,
    input  logic              out_ready,
    output logic              can_take,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    localparam int                CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] hold;
    logic [CNT_W-1:0]  cnt;
    logic              hvalid;
    logic              last_bit;
    logic              completing;
    logic              draining;

    assign last_bit   = (cnt == LAST);
    assign completing = take & last_bit;
    assign draining   = hvalid & out_ready;

    // A draining word frees the holding register in the same cycle, so a
    // finishing word is only refused when the held word is truly stuck.
    assign can_take   = !(last_bit && hvalid && !out_ready);

    assign data  = hold;
    assign valid = hvalid;

    // Shift register and bit counter. The final bit bypasses the shift
    // register and goes straight into the holding register together with
    // the bits gathered so far, so the word is visible one cycle later.
    // A refill in the same cycle as a drain keeps hvalid high with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift  <= '0;
            hold   <= '0;
            cnt    <= '0;
            hvalid <= 1'b0;
        end else begin
            if (take) begin
                if (last_bit) begin
                    hold  <= {bit_in, shift[DATA_W-2:0]};
                    shift <= '0;
                    cnt   <= '0;
                end else begin
                    shift <= shift | (DATA_W'(bit_in) << cnt);
                    cnt   <= cnt + CNT_W'(1);
                end
            end
            if (completing) begin
                hvalid <= 1'b1;
            end else if (draining) begin
                hvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_lane_collector.sv
// ----------------------------------------------------------------------------
// demux_lane_collector
// Consumer for a 1:4 bit demux. Takes the bit the demux steered onto lane
// in_sel and packs it into that lane's word; each lane presents finished
// words on its own valid/ready output.
// Optional feature macro: DEMUX_STEER_CHECK_EN
//   defined   : err is a sticky flag set when, with in_valid high, any lane
//               other than in_sel carries a 1
//   undefined : no check logic, err tied to 0
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : demux output bit valid this cycle
//   in_sel     : lane the demux is steering to
//   in_lanes   : demux outputs; the bit used is in_lanes[in_sel]
//   in_ready   : collector accepts the bit this cycle
//   out_data   : lane k word at [k*DATA_W +: DATA_W]
//   out_valid  : per-lane word available
//   out_ready  : per-lane consumer accept
//   err        : sticky steering error
// ----------------------------------------------------------------------------
module demux_lane_collector
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [LANES-1:0]        in_lanes,
    output logic                    in_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic                    err
);

    logic [LANES-1:0] lane_can_take;
    logic             bit_in;
    logic             accept;

    // Only the selected lane's backpressure matters; other lanes are never
    // touched by this cycle's bit.
    assign bit_in   = in_lanes[in_sel];
    assign in_ready = lane_can_take[in_sel];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_packer #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .take      (accept && (in_sel == SEL_W'(k))),
            .bit_in    (bit_in),
            .out_ready (out_ready[k]),
            .can_take  (lane_can_take[k]),
            .data      (out_data[lane_lo(k, DATA_W) +: DATA_W]),
            .valid     (out_valid[k])
        );
    end

`ifdef DEMUX_STEER_CHECK_EN
    logic err_q;
    logic stray;

    // Any 1 outside the selected lane means the demux and collector disagree
    // about the steering. Checked whenever in_valid is high, even if the bit
    // itself is being held off by backpressure.
    assign stray = in_valid && ((in_lanes & ~(LANES'(1) << in_sel)) != '0);

    // Sticky until reset so a single glitch is never missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (stray) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_lane_collector.sv
// ----------------------------------------------------------------------------
// tb_demux_lane_collector
// Self-checking bench for demux_lane_collector (DATA_W = 8). A behavioural
// model keeps each lane's partial word as an integer plus a bit count and
// each held word with its valid flag; every cycle the DUT outputs are
// compared against it. Directed scenarios are followed by random traffic.
// ----------------------------------------------------------------------------
module tb_demux_lane_collector;
    import demux_pkg::*;

    localparam int DW = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic [SEL_W-1:0]    in_sel;
    logic [LANES-1:0]    in_lanes;
    logic                in_ready;
    logic [LANES*DW-1:0] out_data;
    logic [LANES-1:0]    out_valid;
    logic [LANES-1:0]    out_ready;
    logic                err;

    int total;
    int bad;

    int          model_cnt  [LANES];
    logic [31:0] model_acc  [LANES];
    logic [31:0] model_hold [LANES];
    logic        model_hv   [LANES];
    logic        model_err;
    logic        seen_ready;

    demux_lane_collector #(
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_lanes  (in_lanes),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < LANES; k++) begin
            model_cnt[k]  = 0;
            model_acc[k]  = '0;
            model_hold[k] = '0;
            model_hv[k]   = 1'b0;
        end
        model_err = 1'b0;
    endtask

    function automatic logic [LANES*DW-1:0] expData();
        logic [LANES*DW-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) d[k*DW +: DW] = model_hold[k][DW-1:0];
        return d;
    endfunction

    function automatic logic [LANES-1:0] expValid();
        logic [LANES-1:0] v;
        for (int k = 0; k < LANES; k++) v[k] = model_hv[k];
        return v;
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'(expValid()));
        checkOutput({tag, "_data"},  64'(out_data),  64'(expData()));
        checkOutput({tag, "_err"},   64'(err),       64'(model_err));
    endtask

    // One clock of stimulus: drive on the falling edge, check in_ready
    // against the model, advance the model, then check outputs after the
    // rising edge.
    task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                                 input logic [LANES-1:0] lanes,
                                 input logic [LANES-1:0] ordy);
        logic exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_lanes  = lanes;
        out_ready = ordy;
        #1;
        exp_ready  = !((model_cnt[s] == DW - 1) && model_hv[s] && !ordy[s]);
        seen_ready = in_ready;
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        for (int k = 0; k < LANES; k++)
            if (model_hv[k] && ordy[k]) model_hv[k] = 1'b0;
        if (v && exp_ready) begin
            model_acc[s] = model_acc[s] | (32'(lanes[s]) << model_cnt[s]);
            model_cnt[s]++;
            if (model_cnt[s] == DW) begin
                model_hold[s] = model_acc[s];
                model_hv[s]   = 1'b1;
                model_acc[s]  = '0;
                model_cnt[s]  = 0;
            end
        end
`ifdef DEMUX_STEER_CHECK_EN
        if (v && ((lanes & ~(LANES'(1) << s)) != '0)) model_err = 1'b1;
`endif
        @(posedge clk);
        #1;
        checkAll("cycle");
    endtask

    task automatic sendBit(input logic [SEL_W-1:0] s, input logic b,
                           input logic [LANES-1:0] ordy);
        applyStimulus(1'b1, s, LANES'(b) << s, ordy);
    endtask

    task automatic sendBits(input logic [SEL_W-1:0] s, input logic [31:0] w,
                            input int n, input logic [LANES-1:0] ordy);
        for (int i = 0; i < n; i++) sendBit(s, w[i], ordy);
    endtask

    task automatic doReset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        @(posedge clk);
        #1;
        checkAll("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [LANES-1:0] ordy;
        logic [SEL_W-1:0] s;
        logic             b;
        logic [7:0]       single_word;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sel      = '0;
        in_lanes    = '0;
        out_ready   = '0;
        seen_ready  = 1'b0;
        single_word = 8'b0100_1101;
        modelReset();
        repeat (2) @(posedge clk);
        doReset();

        // Single lane 2: bits 1,0,1,1,0,0,1,0 assemble 8'h4D.
        sendBits(2'd2, 32'(single_word), DW, 4'b1111);
        checkOutput("single_valid", 64'(out_valid), 64'h4);
        checkOutput("single_word",  64'(out_data[2*DW +: DW]), 64'h4D);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);
        checkOutput("single_drained", 64'(out_valid), 64'h0);

        // Interleave lanes 0 and 1: all ones vs all zeros.
        for (int i = 0; i < 2 * DW; i++) begin
            sendBit(2'(i % 2), (i % 2) == 0, 4'b0000);
            if (i == 2 * DW - 2) checkOutput("ilv_lane0_first", 64'(out_valid), 64'h1);
        end
        checkOutput("ilv_both_valid", 64'(out_valid), 64'h3);
        checkOutput("ilv_lane0", 64'(out_data[0 +: DW]), 64'hFF);
        checkOutput("ilv_lane1", 64'(out_data[DW +: DW]), 64'h00);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);

        // Backpressure on lane 3 while building a second word.
        sendBits(2'd3, 32'hA5, DW, 4'b0111);
        sendBits(2'd3, 32'h3C, DW - 1, 4'b0111);
        sendBit(2'd3, 1'b0, 4'b0111);
        checkOutput("bp_stall_ready", 64'(seen_ready), 64'h0);
        checkOutput("bp_held_word", 64'(out_data[3*DW +: DW]), 64'hA5);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b0111);
        checkOutput("bp_other_ready", 64'(seen_ready), 64'h1);
        sendBit(2'd3, 1'b0, 4'b1111);
        checkOutput("bp_release_ready", 64'(seen_ready), 64'h1);
        checkOutput("bp_no_bubble", 64'(out_valid[3]), 64'h1);
        checkOutput("bp_second_word", 64'(out_data[3*DW +: DW]), 64'h3C);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);

        // Drain and refill lane 0 in the same cycle.
        sendBits(2'd0, 32'h5A, DW, 4'b0000);
        sendBits(2'd0, 32'hC3, DW - 1, 4'b0000);
        sendBit(2'd0, 1'b1, 4'b0001);
        checkOutput("refill_valid", 64'(out_valid[0]), 64'h1);
        checkOutput("refill_word", 64'(out_data[0 +: DW]), 64'hC3);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);

        // Reset mid-word with a held word pending; partials must be lost.
        sendBits(2'd2, 32'h77, DW, 4'b0000);
        sendBits(2'd1, 32'hFF, 5, 4'b0000);
        doReset();
        sendBits(2'd1, 32'h81, 3, 4'b0000);
        checkOutput("rst_partial_lost", 64'(out_valid), 64'h0);
        sendBits(2'd1, 32'h81 >> 3, DW - 3, 4'b0000);
        checkOutput("rst_new_valid", 64'(out_valid), 64'h2);
        checkOutput("rst_new_word", 64'(out_data[DW +: DW]), 64'h81);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);

        // Random traffic with clean one-hot steering.
        for (int i = 0; i < 1500; i++) begin
            s    = SEL_W'($urandom_range(0, LANES - 1));
            b    = 1'($urandom_range(0, 1));
            ordy = LANES'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, s, LANES'(b) << s, ordy);
        end
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);

        // Steering error: lane 2 active while lane 1 is selected.
        applyStimulus(1'b1, 2'd1, 4'b0110, 4'b1111);
`ifdef DEMUX_STEER_CHECK_EN
        checkOutput("steer_err_set", 64'(err), 64'h1);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);
        checkOutput("steer_err_sticky", 64'(err), 64'h1);
`else
        checkOutput("steer_err_off", 64'(err), 64'h0);
        applyStimulus(1'b0, 2'd0, 4'b0000, 4'b1111);
        checkOutput("steer_err_off_idle", 64'(err), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
